// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order pipeline. It tracks a 2-bit countdown per
// architectural register and produces the stall, flush and bubble controls for the ID stage.
module hazard_scoreboard #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        ID_valid,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic [4:0]  ID_rd,
   input  logic        ID_use_rs1,
   input  logic        ID_use_rs2,
   input  logic        ID_we,
   input  logic [1:0]  ID_cls,
   input  logic        EX_br_taken,
   output logic        ID_stall,
   output logic        ID_flush,
   output logic        EX_bubble,
   output logic [31:0] busy_mask,
   output logic [15:0] stall_cnt
);

   localparam int unsigned STALL_W = 16;

   // The stall counter must not be wider than the datapath it reports on.
   if (WIDTH < STALL_W) begin : g_width_check
      $error("hazard_scoreboard: WIDTH must be at least 16");
   end

   logic [1:0]         cnt_q [32];
   logic [1:0]         cnt_d [32];
   logic [STALL_W-1:0] stall_cnt_q;
   logic [STALL_W-1:0] stall_cnt_d;

   logic [1:0] lat;
   logic       raw_hz;
   logic       waw_hz;
   logic       issue;

   always_comb begin
      lat = 2'd0;
      case (ID_cls)
         2'b00:   lat = 2'd0;
         2'b01:   lat = 2'd1;
         2'b10:   lat = 2'd2;
         default: lat = 2'd3;
      endcase
   end

   always_comb begin
      raw_hz = 1'b0;
      waw_hz = 1'b0;
      if (ID_valid) begin
         raw_hz = (ID_use_rs1 && (ID_rs1 != 5'd0) && (cnt_q[ID_rs1] != 2'd0)) ||
                  (ID_use_rs2 && (ID_rs2 != 5'd0) && (cnt_q[ID_rs2] != 2'd0));
         waw_hz = ID_we && (ID_rd != 5'd0) && (cnt_q[ID_rd] > lat);
      end
   end

   assign ID_stall  = (raw_hz || waw_hz) && !EX_br_taken;
   assign ID_flush  = EX_br_taken;
   assign EX_bubble = ID_stall || EX_br_taken || !ID_valid;
   assign issue     = ID_valid && !ID_stall && !EX_br_taken;

   // A fresh load of an entry replaces its decrement in the same cycle.
   always_comb begin
      for (int unsigned r = 0; r < 32; r++) begin
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (cnt_q[r] != 2'd0) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end else begin
            cnt_d[r] = '0;
         end
      end
      if (issue && ID_we && (ID_rd != 5'd0) && (lat != 2'd0)) begin
         cnt_d[ID_rd] = lat;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ID_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         busy_mask[r] = (cnt_q[r] != 2'd0);
      end
   end

   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned r = 0; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned r = 0; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
